// File: rtl/apple_spawner.sv
// Apple placement engine: services eaten apples one at a time, drawing LFSR grid
// candidates and checking each against snake body, head and the other live apples.
module apple_spawner #(
    parameter int          N_APPLES  = 2,
    parameter int          GRID_COLS = 31,
    parameter int          GRID_ROWS = 23,
    parameter int          CELL_SIZE = 20,
    parameter int          MAX_RETRY = 8,
    parameter logic [15:0] SEED_X    = 16'hACE1,
    parameter logic [15:0] SEED_Y    = 16'h2409
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_APPLES-1:0]     eat_req,
    input  logic [9:0]              head_x,
    input  logic [9:0]              head_y,
    output logic                    occ_req,
    output logic [9:0]              occ_x,
    output logic [9:0]              occ_y,
    input  logic                    occ_ack,
    input  logic                    occ_hit,
    output logic [10*N_APPLES-1:0]  apple_x,
    output logic [10*N_APPLES-1:0]  apple_y,
    output logic [N_APPLES-1:0]     apple_valid,
    output logic                    busy,
    output logic                    spawned,
    output logic                    spawn_fail
);

    localparam int          IDX_W  = (N_APPLES > 1) ? $clog2(N_APPLES) : 1;
    localparam int          RTY_W  = $clog2(MAX_RETRY + 1);
    localparam logic [31:0] COLS_U = 32'(GRID_COLS);
    localparam logic [31:0] ROWS_U = 32'(GRID_ROWS);
    localparam logic [31:0] CELL_U = 32'(CELL_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_QUERY,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_x_q, lfsr_x_d;
    logic [15:0]         lfsr_y_q, lfsr_y_d;
    logic [N_APPLES-1:0] pending_q, pending_d;
    logic [N_APPLES-1:0] valid_q, valid_d;
    logic [9:0]          ax_q [N_APPLES];
    logic [9:0]          ax_d [N_APPLES];
    logic [9:0]          ay_q [N_APPLES];
    logic [9:0]          ay_d [N_APPLES];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [9:0]          cand_x_q, cand_x_d;
    logic [9:0]          cand_y_q, cand_y_d;
    logic                hit_q, hit_d;
    logic                col_q, col_d;

    logic [IDX_W-1:0]    low_idx;
    logic                apple_col;
    logic                collision;

    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    always_comb begin
        low_idx = '0;
        for (int i = N_APPLES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Only other live apples count; the slot being refilled is already invalid anyway.
    always_comb begin
        apple_col = 1'b0;
        for (int j = 0; j < N_APPLES; j++) begin
            if ((IDX_W'(j) != idx_q) && valid_q[j] &&
                (ax_q[j] == cand_x_q) && (ay_q[j] == cand_y_q)) begin
                apple_col = 1'b1;
            end
        end
    end

    assign collision = hit_q || ((cand_x_q == head_x) && (cand_y_q == head_y)) || apple_col;

    always_comb begin
        state_d   = state_q;
        lfsr_x_d  = lfsr_step(lfsr_x_q);
        lfsr_y_d  = lfsr_step(lfsr_y_q);
        pending_d = pending_q | (eat_req & valid_q);
        valid_d   = valid_q & ~eat_req;
        ax_d      = ax_q;
        ay_d      = ay_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        hit_d     = hit_q;
        col_d     = col_q;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    idx_d   = low_idx;
                    retry_d = '0;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                cand_x_d = 10'((32'(lfsr_x_q) % COLS_U) * CELL_U);
                cand_y_d = 10'((32'(lfsr_y_q) % ROWS_U) * CELL_U);
                retry_d  = retry_q + RTY_W'(1);
                state_d  = S_QUERY;
            end
            S_QUERY: begin
                if (occ_ack) begin
                    hit_d   = occ_hit;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                col_d = collision;
                if (collision && (int'(retry_q) < MAX_RETRY)) begin
                    state_d = S_PICK;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                ax_d[idx_q]      = cand_x_q;
                ay_d[idx_q]      = cand_y_q;
                valid_d[idx_q]   = 1'b1;
                pending_d[idx_q] = 1'b0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_x_q  <= SEED_X;
            lfsr_y_q  <= SEED_Y;
            pending_q <= '0;
            valid_q   <= '1;
            idx_q     <= '0;
            retry_q   <= '0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            hit_q     <= 1'b0;
            col_q     <= 1'b0;
            for (int i = 0; i < N_APPLES; i++) begin
                ax_q[i] <= 10'(100 + 40 * i);
                ay_q[i] <= 10'd100;
            end
        end else begin
            state_q   <= state_d;
            lfsr_x_q  <= lfsr_x_d;
            lfsr_y_q  <= lfsr_y_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            hit_q     <= hit_d;
            col_q     <= col_d;
            for (int i = 0; i < N_APPLES; i++) begin
                ax_q[i] <= ax_d[i];
                ay_q[i] <= ay_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_APPLES; gi++) begin : g_pack
        assign apple_x[10*gi +: 10] = ax_q[gi];
        assign apple_y[10*gi +: 10] = ay_q[gi];
    end

    assign apple_valid = valid_q;
    assign occ_req     = (state_q == S_QUERY);
    assign occ_x       = cand_x_q;
    assign occ_y       = cand_y_q;
    assign busy        = (state_q != S_IDLE);
    assign spawned     = (state_q == S_COMMIT);
    assign spawn_fail  = (state_q == S_COMMIT) && col_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Randomized bench for apple_spawner: a cycle-level reference model predicts
// candidates, collisions, commit order and latency; a monitor scores the DUT.
module tb_apple_spawner;

    localparam int N    = 2;
    localparam int MAXR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  eat_req = '0;
    logic [9:0]    head_x = 10'd1023;
    logic [9:0]    head_y = 10'd1023;
    logic          occ_ack = 1'b0;
    logic          occ_hit = 1'b0;
    logic          occ_req;
    logic [9:0]    occ_x, occ_y;
    logic [10*N-1:0] apple_x, apple_y;
    logic [N-1:0]  apple_valid;
    logic          busy, spawned, spawn_fail;

    apple_spawner #(.N_APPLES(N), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .eat_req(eat_req), .head_x(head_x), .head_y(head_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .busy(busy), .spawned(spawned), .spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        logic fb;
        fb = r[15] ^ r[13] ^ r[12] ^ r[10];
        return {r[14:0], fb};
    endfunction

    function automatic logic [9:0] cand_of(input logic [15:0] r, input int n);
        int v;
        v = (int'(r) % n) * 20;
        return v[9:0];
    endfunction

    // Occupancy responder: ack after ack_delay QUERY cycles; junk acks outside QUERY.
    int ack_delay = 0;
    int hit_mode  = 0;
    int wcnt      = 0;
    always @(negedge clk) begin
        if (occ_req) begin
            if (wcnt >= ack_delay) begin
                occ_ack = 1'b1;
                occ_hit = (hit_mode == 1) ? 1'b1 : (hit_mode == 2) ? 1'($urandom % 2) : 1'b0;
                wcnt    = 0;
            end else begin
                occ_ack = 1'b0;
                wcnt++;
            end
        end else begin
            occ_ack = 1'($urandom % 2);
            occ_hit = 1'($urandom % 2);
            wcnt    = 0;
        end
    end

    // Reference model state
    logic [15:0] m_lx, m_ly, lx_before, ly_before;
    logic [N-1:0] m_valid;
    logic [9:0]  m_ax [N];
    logic [9:0]  m_ay [N];
    int          exp_q[$];
    int          edge_cnt = 0;
    logic        prev_occ_req;
    logic [9:0]  prev_occ_x, prev_occ_y;
    int          hs, waits;
    bit          chk_next, chk_hit, last_col, commit_pend, commit_fail;
    logic [9:0]  chk_x, chk_y, last_x, last_y;
    int          commit_idx;
    int          lat_start [N];
    bit          lat_clean [N];
    int          n_spawn = 0, n_sfail = 0;
    logic [N-1:0] accepted;
    bit          col;

    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (!rst_n) begin
            check("rst_occ_req", occ_req, 0);
            check("rst_busy", busy, 0);
            check("rst_pulses", {spawned, spawn_fail}, 0);
            check("rst_valid", apple_valid, 2'b11);
            check("rst_apple_x", apple_x, {10'd140, 10'd100});
            check("rst_apple_y", apple_y, {10'd100, 10'd100});
            m_lx = 16'hACE1;
            m_ly = 16'h2409;
            m_valid = '1;
            for (int i = 0; i < N; i++) begin
                m_ax[i] = 10'(100 + 40 * i);
                m_ay[i] = 10'd100;
            end
            exp_q.delete();
            hs = 0; waits = 0;
            chk_next = 0; commit_pend = 0; last_col = 0;
            prev_occ_req = 0;
        end else begin
            lx_before = m_lx;
            ly_before = m_ly;
            m_lx = lfsr_next(m_lx);
            m_ly = lfsr_next(m_ly);
            accepted = eat_req & m_valid;

            // Collision decision as seen during the CHECK cycle just ended
            if (chk_next) begin
                col = chk_hit || ((chk_x == head_x) && (chk_y == head_y));
                for (int j = 0; j < N; j++) begin
                    if (exp_q.size() > 0 && j != exp_q[0] && m_valid[j] &&
                        m_ax[j] == chk_x && m_ay[j] == chk_y) col = 1;
                end
                last_col = col;
                last_x = chk_x;
                last_y = chk_y;
                chk_next = 0;
            end

            if (commit_pend) begin
                m_valid[commit_idx] = 1'b1;
                m_ax[commit_idx] = last_x;
                m_ay[commit_idx] = last_y;
                if (lat_clean[commit_idx])
                    check("latency", edge_cnt - lat_start[commit_idx], 5 + 3 * (hs - 1) + waits);
                for (int j = 0; j < N; j++) begin
                    if (j != commit_idx && m_valid[j] && !commit_fail)
                        check("distinct_pos", (m_ax[j] == last_x && m_ay[j] == last_y), 0);
                end
                $display("commit apple %0d at (%0d,%0d) tries=%0d fail=%0d", commit_idx,
                         last_x, last_y, hs, commit_fail);
                hs = 0; waits = 0;
                commit_pend = 0;
            end

            for (int i = 0; i < N; i++) begin
                if (accepted[i]) begin
                    lat_clean[i] = (exp_q.size() == 0);
                    lat_start[i] = edge_cnt;
                    exp_q.push_back(i);
                    m_valid[i] = 1'b0;
                end
            end

            if (spawned) begin
                n_spawn++;
                if (spawn_fail) n_sfail++;
                if (exp_q.size() == 0) begin
                    check("spurious_spawn", 1, 0);
                end else begin
                    commit_idx = exp_q.pop_front();
                    commit_fail = last_col;
                    check("spawn_fail", spawn_fail, last_col);
                    if (last_col) check("retry_count", hs, MAXR);
                    else          check("retry_bound", hs <= MAXR, 1);
                    check("cand_grid", (last_x % 20 == 0) && last_x <= 600 &&
                                       (last_y % 20 == 0) && last_y <= 440, 1);
                    commit_pend = 1;
                end
            end

            if (prev_occ_req && occ_ack) begin
                hs++;
                chk_next = 1;
                chk_x = prev_occ_x;
                chk_y = prev_occ_y;
                chk_hit = occ_hit;
            end else if (prev_occ_req) begin
                waits++;
                check("query_hold", occ_req, 1);
                check("query_x_stable", occ_x, prev_occ_x);
                check("query_y_stable", occ_y, prev_occ_y);
            end
            if (occ_req && !prev_occ_req) begin
                check("cand_x", occ_x, cand_of(lx_before, 31));
                check("cand_y", occ_y, cand_of(ly_before, 23));
            end
            prev_occ_req = occ_req;
            prev_occ_x = occ_x;
            prev_occ_y = occ_y;

            check("apple_valid", apple_valid, m_valid);
            for (int i = 0; i < N; i++) begin
                check("apple_x", apple_x[10*i +: 10], m_ax[i]);
                check("apple_y", apple_y[10*i +: 10], m_ay[i]);
            end
            if (exp_q.size() == 0 && !spawned) begin
                check("idle_busy", busy, 0);
                check("idle_occ_req", occ_req, 0);
            end
        end
    end

    task automatic do_eat(input logic [N-1:0] bits);
        @(negedge clk);
        eat_req = bits;
        @(negedge clk);
        eat_req = '0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((busy || exp_q.size() != 0 || commit_pend) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check({tag, "_timeout"}, t, 0);
        @(negedge clk);
    endtask

    int s0, f0, t;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single eat, immediate ack, no hits
        s0 = n_spawn; f0 = n_sfail;
        do_eat(2'b01);
        wait_idle("single");
        check("single_spawn_count", n_spawn - s0, 1);
        check("single_fail_count", n_sfail - f0, 0);

        // Both apples eaten in the same cycle
        s0 = n_spawn;
        do_eat(2'b11);
        wait_idle("double");
        check("double_spawn_count", n_spawn - s0, 2);

        // Every query hits: retries exhaust and the last candidate is forced
        hit_mode = 1; f0 = n_sfail;
        do_eat(2'b10);
        wait_idle("exhaust");
        check("exhaust_fail_count", n_sfail - f0, 1);
        hit_mode = 0;

        // Long ack stall
        ack_delay = 20; s0 = n_spawn;
        do_eat(2'b01);
        wait_idle("stall");
        check("stall_spawn_count", n_spawn - s0, 1);
        ack_delay = 0;

        // Randomized traffic including eats during busy
        for (int it = 0; it < 40; it++) begin
            hit_mode  = $urandom % 3;
            ack_delay = $urandom % 4;
            head_x    = 10'(($urandom % 31) * 20);
            head_y    = 10'(($urandom % 23) * 20);
            do_eat(2'($urandom_range(1, 3)));
            repeat ($urandom % 6) @(negedge clk);
            if ($urandom % 2) do_eat(2'($urandom_range(1, 3)));
            wait_idle("random");
        end
        hit_mode = 0; ack_delay = 10;
        head_x = 10'd1023; head_y = 10'd1023;

        // Reset asserted while a query is outstanding
        do_eat(2'b01);
        t = 0;
        while (!occ_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reach_query", occ_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_occ_req", occ_req, 0);
        check("async_busy", busy, 0);
        check("async_valid", apple_valid, 2'b11);
        check("async_apple_x", apple_x, {10'd140, 10'd100});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (10) @(negedge clk);
        s0 = n_spawn;
        do_eat(2'b10);
        wait_idle("post_reset");
        check("post_reset_spawn_count", n_spawn - s0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
